// File: rtl/sc_level_progress_tracker_pkg.sv
// rtl/sc_level_progress_tracker_pkg.sv - shared frogger level-progress types and defaults
//
// Purpose : state encoding and default game constants for the level tracker.
// Ports   : none (package).
package sc_frogger_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PLAYING     = 2'd1,
        LEVEL_CLEAR = 2'd2,
        WON         = 2'd3
    } trackerState_t;

    localparam int DEFAULT_MAX_LEVEL       = 20;
    localparam int DEFAULT_HOMES_PER_LEVEL = 5;

endpackage

// File: rtl/sc_level_progress_tracker_if.sv
// rtl/sc_level_progress_tracker_if.sv - control/status bundle between game logic and level tracker
//
// Purpose : groups the run-control inputs and the progress outputs of the tracker.
// Signals : Start_In, GameOver_In, Goal_In (game logic -> tracker)
//           Level_OutBus, Homes_OutBus, LevelUp_Out, Pause_Out, Playing_Out, Won_Out (tracker -> game logic)
// Modports: master = frog/collision/score side, slave = the tracker.
interface sc_level_progress_tracker_if #(
    parameter int LEVEL_WIDTH = 5,
    parameter int HOME_WIDTH  = 3
);
    logic                   SC_LEVELPROGRESSTRACKER_Start_In;
    logic                   SC_LEVELPROGRESSTRACKER_GameOver_In;
    logic                   SC_LEVELPROGRESSTRACKER_Goal_In;
    logic [LEVEL_WIDTH-1:0] SC_LEVELPROGRESSTRACKER_Level_OutBus;
    logic [HOME_WIDTH-1:0]  SC_LEVELPROGRESSTRACKER_Homes_OutBus;
    logic                   SC_LEVELPROGRESSTRACKER_LevelUp_Out;
    logic                   SC_LEVELPROGRESSTRACKER_Pause_Out;
    logic                   SC_LEVELPROGRESSTRACKER_Playing_Out;
    logic                   SC_LEVELPROGRESSTRACKER_Won_Out;

    modport master (
        output SC_LEVELPROGRESSTRACKER_Start_In,
        output SC_LEVELPROGRESSTRACKER_GameOver_In,
        output SC_LEVELPROGRESSTRACKER_Goal_In,
        input  SC_LEVELPROGRESSTRACKER_Level_OutBus,
        input  SC_LEVELPROGRESSTRACKER_Homes_OutBus,
        input  SC_LEVELPROGRESSTRACKER_LevelUp_Out,
        input  SC_LEVELPROGRESSTRACKER_Pause_Out,
        input  SC_LEVELPROGRESSTRACKER_Playing_Out,
        input  SC_LEVELPROGRESSTRACKER_Won_Out
    );

    modport slave (
        input  SC_LEVELPROGRESSTRACKER_Start_In,
        input  SC_LEVELPROGRESSTRACKER_GameOver_In,
        input  SC_LEVELPROGRESSTRACKER_Goal_In,
        output SC_LEVELPROGRESSTRACKER_Level_OutBus,
        output SC_LEVELPROGRESSTRACKER_Homes_OutBus,
        output SC_LEVELPROGRESSTRACKER_LevelUp_Out,
        output SC_LEVELPROGRESSTRACKER_Pause_Out,
        output SC_LEVELPROGRESSTRACKER_Playing_Out,
        output SC_LEVELPROGRESSTRACKER_Won_Out
    );
endinterface

// File: rtl/sc_rise_edge_detect.sv
// rtl/sc_rise_edge_detect.sv - rising-edge detector for level strobes and buttons
//
// Purpose : one-cycle rise indication from a level input; the delayed copy
//           updates every cycle so a held level never fires twice.
// Ports   : SC_RISEEDGEDETECT_CLOCK_50     in  clock
//           SC_RISEEDGEDETECT_RESET_InLow  in  async active-low reset
//           SC_RISEEDGEDETECT_Signal_In    in  level input
//           SC_RISEEDGEDETECT_Rise_Out     out Signal_In & ~previous Signal_In
module sc_rise_edge_detect (
    input  logic SC_RISEEDGEDETECT_CLOCK_50,
    input  logic SC_RISEEDGEDETECT_RESET_InLow,
    input  logic SC_RISEEDGEDETECT_Signal_In,
    output logic SC_RISEEDGEDETECT_Rise_Out
);
    logic signalDelayed;

    always_ff @(posedge SC_RISEEDGEDETECT_CLOCK_50 or negedge SC_RISEEDGEDETECT_RESET_InLow) begin
        if (!SC_RISEEDGEDETECT_RESET_InLow) begin
            signalDelayed <= 1'b0;
        end else begin
            signalDelayed <= SC_RISEEDGEDETECT_Signal_In;
        end
    end

    // Cleared delay at reset means a level already high at release counts once.
    assign SC_RISEEDGEDETECT_Rise_Out = SC_RISEEDGEDETECT_Signal_In & ~signalDelayed;
endmodule

// File: rtl/sc_level_progress_tracker.sv
// rtl/sc_level_progress_tracker.sv - counts homes per level, pauses between levels, flags win or wraps
//
// Purpose : level/home progress FSM (IDLE, PLAYING, LEVEL_CLEAR, WON) with an
//           inter-level pause of CLEAR_HOLD cycles. All outputs are registered.
// Ports   : SC_LEVELPROGRESSTRACKER_CLOCK_50     in  clock, rising edge
//           SC_LEVELPROGRESSTRACKER_RESET_InLow  in  async active-low reset
//           trackerBus (slave)                       Start/GameOver/Goal in,
//                                                    Level/Homes/LevelUp/Pause/Playing/Won out
module sc_level_progress_tracker
    import sc_frogger_pkg::*;
#(
    parameter int LEVEL_WIDTH     = 5,
    parameter int MAX_LEVEL       = DEFAULT_MAX_LEVEL,
    parameter int HOMES_PER_LEVEL = DEFAULT_HOMES_PER_LEVEL,
    parameter int HOME_WIDTH      = 3,
    parameter int CLEAR_HOLD      = 4,
    parameter int HOLD_WIDTH      = 26,
    parameter int WRAP_MODE       = 0
) (
    input  logic SC_LEVELPROGRESSTRACKER_CLOCK_50,
    input  logic SC_LEVELPROGRESSTRACKER_RESET_InLow,
    sc_level_progress_tracker_if.slave trackerBus
);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_LAST = LEVEL_WIDTH'(MAX_LEVEL - 1);
    localparam logic [HOME_WIDTH-1:0]  HOMES_LAST = HOME_WIDTH'(HOMES_PER_LEVEL - 1);
    localparam logic [HOLD_WIDTH-1:0]  HOLD_LOAD  = HOLD_WIDTH'(CLEAR_HOLD - 1);

    trackerState_t           state, stateNext;
    logic [LEVEL_WIDTH-1:0]  levelReg, levelNext;
    logic [HOME_WIDTH-1:0]   homesReg, homesNext;
    logic [HOLD_WIDTH-1:0]   holdReg, holdNext;
    logic                    levelUpReg, levelUpNext;
    logic                    pauseReg, pauseNext;
    logic                    playingReg, playingNext;
    logic                    wonReg, wonNext;
    logic                    goalRise;
    logic                    startIn, gameOverIn;

    assign startIn    = trackerBus.SC_LEVELPROGRESSTRACKER_Start_In;
    assign gameOverIn = trackerBus.SC_LEVELPROGRESSTRACKER_GameOver_In;

    sc_rise_edge_detect goalEdge (
        .SC_RISEEDGEDETECT_CLOCK_50    (SC_LEVELPROGRESSTRACKER_CLOCK_50),
        .SC_RISEEDGEDETECT_RESET_InLow (SC_LEVELPROGRESSTRACKER_RESET_InLow),
        .SC_RISEEDGEDETECT_Signal_In   (trackerBus.SC_LEVELPROGRESSTRACKER_Goal_In),
        .SC_RISEEDGEDETECT_Rise_Out    (goalRise)
    );

    // State and registered outputs.
    always_ff @(posedge SC_LEVELPROGRESSTRACKER_CLOCK_50 or negedge SC_LEVELPROGRESSTRACKER_RESET_InLow) begin
        if (!SC_LEVELPROGRESSTRACKER_RESET_InLow) begin
            state      <= IDLE;
            levelReg   <= '0;
            homesReg   <= '0;
            holdReg    <= '0;
            levelUpReg <= 1'b0;
            pauseReg   <= 1'b0;
            playingReg <= 1'b0;
            wonReg     <= 1'b0;
        end else begin
            state      <= stateNext;
            levelReg   <= levelNext;
            homesReg   <= homesNext;
            holdReg    <= holdNext;
            levelUpReg <= levelUpNext;
            pauseReg   <= pauseNext;
            playingReg <= playingNext;
            wonReg     <= wonNext;
        end
    end

    // Next state and datapath. Priority: Start > GameOver > goal rise > hold expiry.
    always_comb begin
        stateNext = state;
        levelNext = levelReg;
        homesNext = homesReg;
        holdNext  = holdReg;
        case (state)
            IDLE: begin
                if (startIn) begin
                    stateNext = PLAYING;
                    levelNext = '0;
                    homesNext = '0;
                end
            end
            PLAYING: begin
                if (startIn) begin
                    levelNext = '0;
                    homesNext = '0;
                end else if (gameOverIn) begin
                    // Level and homes are kept so the display can show the final score.
                    stateNext = IDLE;
                end else if (goalRise) begin
                    if (homesReg >= HOMES_LAST) begin
                        homesNext = '0;
                        holdNext  = HOLD_LOAD;
                        stateNext = LEVEL_CLEAR;
                    end else begin
                        homesNext = homesReg + 1'b1;
                    end
                end
            end
            LEVEL_CLEAR: begin
                if (startIn) begin
                    stateNext = PLAYING;
                    levelNext = '0;
                    homesNext = '0;
                end else if (gameOverIn) begin
                    stateNext = IDLE;
                end else if (holdReg == '0) begin
                    if (levelReg < LEVEL_LAST) begin
                        levelNext = levelReg + 1'b1;
                        stateNext = PLAYING;
                    end else if (WRAP_MODE != 0) begin
                        levelNext = '0;
                        stateNext = PLAYING;
                    end else begin
                        stateNext = WON;
                    end
                end else begin
                    holdNext = holdReg - 1'b1;
                end
            end
            WON: begin
                if (startIn) begin
                    stateNext = PLAYING;
                    levelNext = '0;
                    homesNext = '0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        levelUpNext = (state == PLAYING) && (stateNext == LEVEL_CLEAR);
        pauseNext   = (stateNext == LEVEL_CLEAR);
        playingNext = (stateNext == PLAYING);
        wonNext     = (stateNext == WON);
    end

    assign trackerBus.SC_LEVELPROGRESSTRACKER_Level_OutBus = levelReg;
    assign trackerBus.SC_LEVELPROGRESSTRACKER_Homes_OutBus = homesReg;
    assign trackerBus.SC_LEVELPROGRESSTRACKER_LevelUp_Out  = levelUpReg;
    assign trackerBus.SC_LEVELPROGRESSTRACKER_Pause_Out    = pauseReg;
    assign trackerBus.SC_LEVELPROGRESSTRACKER_Playing_Out  = playingReg;
    assign trackerBus.SC_LEVELPROGRESSTRACKER_Won_Out      = wonReg;
endmodule

// File: doc/sc_level_progress_tracker.md
Name: sc_level_progress_tracker

Overview:
- Parametrised successor to the single-register level counter.
- Counts frogs reaching home (rising edges of a goal strobe) and advances the level after HOMES_PER_LEVEL homes.
- Holds an inter-level pause, then either flags game won or wraps to level 0, depending on mode.
- Sits between the frog/collision logic and the score/display/speed-select logic.

Parameters:
LEVEL_WIDTH, 5, width of level output; MAX_LEVEL must be ≤ 2^LEVEL_WIDTH-1
MAX_LEVEL, 20, number of levels; completing level MAX_LEVEL-1 ends the run
HOMES_PER_LEVEL, 5, goal edges needed to clear one level (≥1)
HOME_WIDTH, 3, width of home counter; HOMES_PER_LEVEL-1 must fit
CLEAR_HOLD, 4, cycles spent in LEVEL_CLEAR, during which goals are ignored (≥1)
HOLD_WIDTH, 26, width of pause counter; CLEAR_HOLD-1 must fit
WRAP_MODE, 0, 0 = stop in WON at the end; 1 = wrap level to 0 and keep playing

Ports:
SC_LEVELPROGRESSTRACKER_CLOCK_50  in  1  sole clock, rising edge
SC_LEVELPROGRESSTRACKER_RESET_InLow  in  1  asynchronous, active-low reset
SC_LEVELPROGRESSTRACKER_Start_In  in  1  synchronous start/restart of a run
SC_LEVELPROGRESSTRACKER_GameOver_In  in  1  synchronous abort (frog lives exhausted)
SC_LEVELPROGRESSTRACKER_Goal_In  in  1  level signal, high while frog is in home row
SC_LEVELPROGRESSTRACKER_Level_OutBus  out  LEVEL_WIDTH  current level, 0-based
SC_LEVELPROGRESSTRACKER_Homes_OutBus  out  HOME_WIDTH  homes reached in current level
SC_LEVELPROGRESSTRACKER_LevelUp_Out  out  1  one-cycle pulse on level completion
SC_LEVELPROGRESSTRACKER_Pause_Out  out  1  high while in LEVEL_CLEAR
SC_LEVELPROGRESSTRACKER_Playing_Out  out  1  high in PLAYING
SC_LEVELPROGRESSTRACKER_Won_Out  out  1  high in WON (sticky until Start or reset)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state IDLE; level, homes, hold counter, goal_d and all outputs = 0.
- All outputs are registered. An input sampled at edge n is reflected at edge n+1.
- Edge detect: goal_rise = Goal_In & ~goal_d.
  - goal_d updates every cycle in every state.
  - A goal held high across Start, pause or reset exit never counts twice.
  - Reset clears goal_d, so a goal already high at reset release counts once, and only if the state is PLAYING.
- Priority per cycle: Start > GameOver > goal_rise > hold expiry.
- States and transitions:
  - IDLE: wait. Start -> PLAYING with level=0, homes=0.
  - PLAYING, Start: clear level and homes, stay in PLAYING.
  - PLAYING, GameOver: -> IDLE; level and homes keep their values for the display.
  - PLAYING, goal_rise with homes < HOMES_PER_LEVEL-1: homes+1.
  - PLAYING, goal_rise with homes = HOMES_PER_LEVEL-1: homes=0, LevelUp_Out=1 for exactly one cycle, hold counter loaded with CLEAR_HOLD-1, -> LEVEL_CLEAR.
  - LEVEL_CLEAR: goal_rise is ignored and the hold counter decrements. GameOver -> IDLE. Start -> PLAYING with level/homes cleared.
  - LEVEL_CLEAR, hold counter = 0 and level < MAX_LEVEL-1: level+1, -> PLAYING.
  - LEVEL_CLEAR, hold counter = 0 and level = MAX_LEVEL-1: WRAP_MODE=0 -> WON, level stays MAX_LEVEL-1. WRAP_MODE=1 -> level=0, -> PLAYING.
  - WON: everything is frozen and GameOver is ignored. Start -> PLAYING with level/homes cleared.
- Pause duration: LEVEL_CLEAR lasts exactly CLEAR_HOLD cycles.
- Arithmetic: level and homes never exceed their limits and never wrap silently (wrap only via WRAP_MODE). Comparisons are unsigned at full parameter width.
- Mid-operation: asserting reset at any point returns to reset values asynchronously. There is no partial pulse on LevelUp_Out.

Decomposition:
- Shared package (sc_frogger_pkg):
  - state encoding IDLE=2'd0, PLAYING=2'd1, LEVEL_CLEAR=2'd2, WON=2'd3
  - default MAX_LEVEL / HOMES_PER_LEVEL constants
- One natural sub-module: sc_rise_edge_detect (goal_d register plus AND), reusable for other button and strobe inputs.
- The pause counter stays inline.

Test Plan (MAX_LEVEL=3, HOMES_PER_LEVEL=2, CLEAR_HOLD=4, WRAP_MODE=0 unless stated):
1. Reset low, then high. Pulse Start. Hold Goal high for 10 cycles -> Homes=1 once only, Level=0, LevelUp never asserted.
2. From level 0, two separate goal pulses -> LevelUp high for 1 cycle and Pause high for exactly 4 cycles. Goal pulses during the pause are ignored. Level=1 and Playing=1 afterwards.
3. Complete 3 levels (6 goal pulses) -> after the final pause Won=1, Level=2, Playing=0. Further goals and GameOver change nothing. Start -> Level=0, Playing=1.
4. WRAP_MODE=1, complete 3 levels -> Level returns to 0, Playing=1, Won never asserted.
5. Start and Goal rise in the same cycle while PLAYING with Homes=1 -> Level=0, Homes=0, no LevelUp. GameOver while Level=1, Homes=1 -> IDLE with Level=1 and Homes=1 held.
6. Reset driven low mid-pause (Level=1) -> all outputs 0 immediately. After release, state is IDLE until Start.
